sweep_compare_ctrl: RTL and testbench

- Sequential controller that exhaustively sweeps all input vectors of a small combinational benchmark.
- Drives one shared input bus into two netlists of that benchmark: the ABC-optimized netlist and the golden netlist.
- Waits a programmable settle time, samples both output buses and compares them.
- Reports pass/fail, mismatch count and first failing vector; used for on-chip/FPGA equivalence checking of synthesized cases (6-input/3-output class).

---
 rtl/sweep_compare_ctrl_if.sv | 44 ++++
 rtl/sweep_compare_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_sweep_compare_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sweep_compare_ctrl_if.sv
// Interface for sweep_compare_ctrl.
// Groups the sweep control/status bus and the two compared netlist output buses.
// When SWEEP_SIGNATURE_EN is defined, the interface also carries the 16-bit MISR signature.
// The slave modport is the controller; the master modport is the host/netlist side.
interface sweep_compare_ctrl_if #(
    parameter int VEC_W = 6,
    parameter int OUT_W = 3
);
    logic             start;
    logic             abort;
    logic             stop_on_fail;
    logic [VEC_W-1:0] vec;
    logic [OUT_W-1:0] y_dut;
    logic [OUT_W-1:0] y_ref;
    logic             busy;
    logic             done;
    logic             pass;
    logic [VEC_W:0]   mismatch_cnt;
    logic [VEC_W-1:0] first_fail_vec;
    logic [OUT_W-1:0] first_fail_xor;
`ifdef SWEEP_SIGNATURE_EN
    logic [15:0]      signature;

    modport slave (
        input  start, abort, stop_on_fail, y_dut, y_ref,
        output vec, busy, done, pass, mismatch_cnt, first_fail_vec, first_fail_xor, signature
    );

    modport master (
        output start, abort, stop_on_fail, y_dut, y_ref,
        input  vec, busy, done, pass, mismatch_cnt, first_fail_vec, first_fail_xor, signature
    );
`else
    modport slave (
        input  start, abort, stop_on_fail, y_dut, y_ref,
        output vec, busy, done, pass, mismatch_cnt, first_fail_vec, first_fail_xor
    );

    modport master (
        output start, abort, stop_on_fail, y_dut, y_ref,
        input  vec, busy, done, pass, mismatch_cnt, first_fail_vec, first_fail_xor
    );
`endif
endinterface

// File: rtl/sweep_compare_ctrl.sv
// sweep_compare_ctrl: exhaustive equivalence sweep of two combinational netlists.
// Drives every vector 0 .. 2^VEC_W-1 to both netlists, holds each vector for
// SETTLE+1 cycles, compares the outputs in the last cycle, and reports
// pass / mismatch count / first failing vector.
// Optional feature macro: SWEEP_SIGNATURE_EN adds a 16-bit MISR over y_dut.
// All outputs are driven straight from registers.
module sweep_compare_ctrl #(
    parameter int VEC_W  = 6,
    parameter int OUT_W  = 3,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sweep_compare_ctrl_if.slave  bus
);

    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [VEC_W-1:0] VEC_MAX  = {VEC_W{1'b1}};
    localparam logic [VEC_W-1:0] VEC_ONE  = VEC_W'(1);
    localparam logic [VEC_W:0]   MM_ONE   = (VEC_W + 1)'(1);
    localparam logic [VEC_W:0]   MM_ZERO  = (VEC_W + 1)'(0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t           state_r,   state_nxt_s;
    logic [VEC_W-1:0] vec_r,     vec_nxt_s;
    logic [CNT_W-1:0] cnt_r,     cnt_nxt_s;
    logic [VEC_W:0]   mm_cnt_r,  mm_cnt_nxt_s;
    logic [VEC_W-1:0] ffv_r,     ffv_nxt_s;
    logic [OUT_W-1:0] ffx_r,     ffx_nxt_s;
    logic             busy_r,    busy_nxt_s;
    logic             done_r,    done_nxt_s;
    logic             pass_r,    pass_nxt_s;
    logic             sof_r,     sof_nxt_s;
    logic [OUT_W-1:0] x_s;
    logic [VEC_W:0]   mm_upd_s;

`ifdef SWEEP_SIGNATURE_EN
    logic [15:0]      sig_r,     sig_nxt_s;

    // One MISR step: shift with feedback taps 15/13/12/10, then fold in the data word.
    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [OUT_W-1:0] din);
        logic [15:0] din_ext;
        din_ext = 16'(din);
        return {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10]} ^ din_ext;
    endfunction
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-datapath decisions for the sweep.
    always_comb begin
        state_nxt_s  = state_r;
        vec_nxt_s    = vec_r;
        cnt_nxt_s    = cnt_r;
        mm_cnt_nxt_s = mm_cnt_r;
        ffv_nxt_s    = ffv_r;
        ffx_nxt_s    = ffx_r;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        pass_nxt_s   = pass_r;
        sof_nxt_s    = sof_r;
        x_s          = bus.y_dut ^ bus.y_ref;
        mm_upd_s     = mm_cnt_r;
`ifdef SWEEP_SIGNATURE_EN
        sig_nxt_s    = sig_r;
`endif

        case (state_r)
            ST_IDLE: begin
                if (bus.abort) begin
                    // Abort has priority over start; remain idle.
                    state_nxt_s = ST_IDLE;
                end else if (bus.start) begin
                    vec_nxt_s    = {VEC_W{1'b0}};
                    mm_cnt_nxt_s = MM_ZERO;
                    ffv_nxt_s    = {VEC_W{1'b0}};
                    ffx_nxt_s    = {OUT_W{1'b0}};
                    pass_nxt_s   = 1'b0;
                    sof_nxt_s    = bus.stop_on_fail;
                    busy_nxt_s   = 1'b1;
                    cnt_nxt_s    = CNT_LOAD;
`ifdef SWEEP_SIGNATURE_EN
                    sig_nxt_s    = 16'h0000;
`endif
                    state_nxt_s  = (SETTLE == 0) ? ST_COMPARE : ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                    pass_nxt_s  = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    // The counter reaches zero this cycle: the vector has now been held SETTLE cycles.
                    if (cnt_r <= CNT_ONE) begin
                        state_nxt_s = ST_COMPARE;
                    end else begin
                        state_nxt_s = ST_SETTLE;
                    end
                end
            end

            ST_COMPARE: begin
                if (bus.abort) begin
                    // The compare in this cycle is discarded.
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                    pass_nxt_s  = 1'b0;
                end else begin
                    if (|x_s) begin
                        mm_upd_s = mm_cnt_r + MM_ONE;
                        if (mm_cnt_r == MM_ZERO) begin
                            ffv_nxt_s = vec_r;
                            ffx_nxt_s = x_s;
                        end else begin
                            ffv_nxt_s = ffv_r;
                            ffx_nxt_s = ffx_r;
                        end
                    end else begin
                        mm_upd_s = mm_cnt_r;
                    end
                    mm_cnt_nxt_s = mm_upd_s;
`ifdef SWEEP_SIGNATURE_EN
                    sig_nxt_s    = misr_step(sig_r, bus.y_dut);
`endif
                    if ((vec_r == VEC_MAX) || (sof_r && (|x_s))) begin
                        // Sweep ends: done pulse and pass are visible during the DONE cycle.
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                        busy_nxt_s  = 1'b0;
                        pass_nxt_s  = (mm_upd_s == MM_ZERO);
                    end else begin
                        vec_nxt_s   = vec_r + VEC_ONE;
                        cnt_nxt_s   = CNT_LOAD;
                        state_nxt_s = (SETTLE == 0) ? ST_COMPARE : ST_SETTLE;
                    end
                end
            end

            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end

            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_r    <= {VEC_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            mm_cnt_r <= MM_ZERO;
            ffv_r    <= {VEC_W{1'b0}};
            ffx_r    <= {OUT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            sof_r    <= 1'b0;
        end else begin
            vec_r    <= vec_nxt_s;
            cnt_r    <= cnt_nxt_s;
            mm_cnt_r <= mm_cnt_nxt_s;
            ffv_r    <= ffv_nxt_s;
            ffx_r    <= ffx_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            pass_r   <= pass_nxt_s;
            sof_r    <= sof_nxt_s;
        end
    end

`ifdef SWEEP_SIGNATURE_EN
    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= 16'h0000;
        end else begin
            sig_r <= sig_nxt_s;
        end
    end

    assign bus.signature = sig_r;
`endif

    assign bus.vec            = vec_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.pass           = pass_r;
    assign bus.mismatch_cnt   = mm_cnt_r;
    assign bus.first_fail_vec = ffv_r;
    assign bus.first_fail_xor = ffx_r;

endmodule

// File: tb/tb_sweep_compare_ctrl.sv
// Self-checking bench for sweep_compare_ctrl (SETTLE=1 and SETTLE=0 instances).
// Expected sweep results come from a behavioural model and are queued when a sweep is started;
// they are compared when the done pulse is observed.
module tb_sweep_compare_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [5:0] fa_vec = 6'd0, fb_vec = 6'd0;
    logic [2:0] fa_mask = 3'd0, fb_mask = 3'd0;

    typedef struct {
        int          cycles;
        logic [6:0]  mm;
        logic [5:0]  ffv;
        logic [2:0]  ffx;
        logic [5:0]  vec;
        logic        pass;
        logic [15:0] sig;
    } exp_t;

    exp_t sb_q[$];

    sweep_compare_ctrl_if #(.VEC_W(6), .OUT_W(3)) bus1 ();
    sweep_compare_ctrl_if #(.VEC_W(6), .OUT_W(3)) bus0 ();

    sweep_compare_ctrl #(.VEC_W(6), .OUT_W(3), .SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    sweep_compare_ctrl #(.VEC_W(6), .OUT_W(3), .SETTLE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    always #5 clk = ~clk;

    function automatic logic [2:0] golden(input logic [5:0] v);
        return {v[5] ^ v[1] ^ v[0], v[2] & v[4], v[3] | v[0]};
    endfunction

    function automatic logic [2:0] fmask(input logic [5:0] v, input logic [5:0] av, input logic [2:0] am,
                                         input logic [5:0] bv, input logic [2:0] bm);
        logic [2:0] m;
        m = 3'd0;
        if (v == av) m = m | am;
        if (v == bv) m = m | bm;
        return m;
    endfunction

    assign bus1.y_ref = golden(bus1.vec);
    assign bus1.y_dut = golden(bus1.vec) ^ fmask(bus1.vec, fa_vec, fa_mask, fb_vec, fb_mask);
    assign bus0.y_ref = golden(bus0.vec);
    assign bus0.y_dut = golden(bus0.vec) ^ fmask(bus0.vec, fa_vec, fa_mask, fb_vec, fb_mask);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Behavioural model of a whole sweep with the current fault table.
    task automatic push_expected(input int settle, input logic sof);
        exp_t e;
        int n;
        logic [2:0] x;
        logic [5:0] v6;
        e.mm = 7'd0; e.ffv = 6'd0; e.ffx = 3'd0; e.sig = 16'h0000; e.vec = 6'd0; n = 0;
        for (int v = 0; v < 64; v++) begin
            v6 = v[5:0];
            x = fmask(v6, fa_vec, fa_mask, fb_vec, fb_mask);
            n++;
            e.vec = v6;
            e.sig = {e.sig[14:0], e.sig[15] ^ e.sig[13] ^ e.sig[12] ^ e.sig[10]} ^ {13'd0, golden(v6) ^ x};
            if (x != 3'd0) begin
                if (e.mm == 7'd0) begin
                    e.ffv = v6;
                    e.ffx = x;
                end
                e.mm = e.mm + 7'd1;
                if (sof) break;
            end
        end
        e.cycles = n * (settle + 1);
        e.pass = (e.mm == 7'd0);
        sb_q.push_back(e);
    endtask

    task automatic start_sweep(input int sel, input logic sof, input bit push, input string tag);
        @(negedge clk);
        if (sel == 0) begin bus0.stop_on_fail = sof; bus0.start = 1'b1; end
        else begin bus1.stop_on_fail = sof; bus1.start = 1'b1; end
        if (push) push_expected((sel == 0) ? 0 : 1, sof);
        @(posedge clk); #1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        check({tag, "_busy_rise"}, (sel == 0) ? bus0.busy : bus1.busy, 1);
        check({tag, "_vec_clr"}, (sel == 0) ? bus0.vec : bus1.vec, 0);
        check({tag, "_mm_clr"}, (sel == 0) ? bus0.mismatch_cnt : bus1.mismatch_cnt, 0);
    endtask

    // Waits for done (bounded), optionally pulses start mid-sweep, then pops and compares.
    task automatic wait_done(input int sel, input int pulse_at, input string tag);
        exp_t e;
        int cyc;
        bit seen;
        int settle;
        settle = (sel == 0) ? 0 : 1;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == pulse_at) begin
                if (sel == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
            end else begin
                bus0.start = 1'b0;
                bus1.start = 1'b0;
            end
            if (cyc == 10) check({tag, "_hold"}, (sel == 0) ? bus0.vec : bus1.vec, 10 / (settle + 1));
            if ((sel == 0) ? bus0.done : bus1.done) seen = 1'b1;
        end
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        if (sb_q.size() == 0) begin
            $fatal(1, "FAIL %s scoreboard empty", tag);
        end
        e = sb_q.pop_front();
        check({tag, "_cycles"}, cyc, e.cycles);
        check({tag, "_pass"}, (sel == 0) ? bus0.pass : bus1.pass, e.pass);
        check({tag, "_mm"}, (sel == 0) ? bus0.mismatch_cnt : bus1.mismatch_cnt, e.mm);
        check({tag, "_ffv"}, (sel == 0) ? bus0.first_fail_vec : bus1.first_fail_vec, e.ffv);
        check({tag, "_ffx"}, (sel == 0) ? bus0.first_fail_xor : bus1.first_fail_xor, e.ffx);
        check({tag, "_vec"}, (sel == 0) ? bus0.vec : bus1.vec, e.vec);
        check({tag, "_busy_low"}, (sel == 0) ? bus0.busy : bus1.busy, 0);
`ifdef SWEEP_SIGNATURE_EN
        check({tag, "_sig"}, (sel == 0) ? bus0.signature : bus1.signature, e.sig);
`endif
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, (sel == 0) ? bus0.done : bus1.done, 0);
    endtask

    task automatic wait_vec1(input logic [5:0] target, input string tag);
        int n;
        n = 0;
        while (bus1.vec != target && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_vec_reached"}, bus1.vec, target);
    endtask

    task automatic check_zero1(input string tag);
        check({tag, "_busy"}, bus1.busy, 0);
        check({tag, "_done"}, bus1.done, 0);
        check({tag, "_pass"}, bus1.pass, 0);
        check({tag, "_vec"}, bus1.vec, 0);
        check({tag, "_mm"}, bus1.mismatch_cnt, 0);
        check({tag, "_ffv"}, bus1.first_fail_vec, 0);
        check({tag, "_ffx"}, bus1.first_fail_xor, 0);
`ifdef SWEEP_SIGNATURE_EN
        check({tag, "_sig"}, bus1.signature, 0);
`endif
    endtask

    initial begin
        bit done_seen;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.stop_on_fail = 1'b0;
        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.stop_on_fail = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_zero1("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        bus1.start = 1'b1; bus1.abort = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0; bus1.abort = 1'b0;
        check("start_abort_idle_busy", bus1.busy, 0);

        // Identical netlists, SETTLE=1
        start_sweep(1, 1'b0, 1'b1, "ident1");
        wait_done(1, 0, "ident1");

        // Single fault at 37, bit1
        fa_vec = 6'd37; fa_mask = 3'b010;
        start_sweep(1, 1'b0, 1'b1, "f37");
        wait_done(1, 0, "f37");

        // Faults at 5 and 9, stop_on_fail then not
        fa_vec = 6'd5; fa_mask = 3'b001; fb_vec = 6'd9; fb_mask = 3'b100;
        start_sweep(1, 1'b1, 1'b1, "sof1");
        wait_done(1, 0, "sof1");
        start_sweep(1, 1'b0, 1'b1, "sof0");
        wait_done(1, 0, "sof0");

        // Abort at vec=20 keeps partial results
        start_sweep(1, 1'b0, 1'b0, "abort");
        wait_vec1(6'd20, "abort");
        bus1.abort = 1'b1;
        @(posedge clk); #1;
        bus1.abort = 1'b0;
        check("abort_busy", bus1.busy, 0);
        check("abort_done", bus1.done, 0);
        check("abort_pass", bus1.pass, 0);
        check("abort_vec", bus1.vec, 20);
        check("abort_mm", bus1.mismatch_cnt, 2);
        check("abort_ffv", bus1.first_fail_vec, 5);
        done_seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus1.done) done_seen = 1'b1;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_vec_hold", bus1.vec, 20);
        start_sweep(1, 1'b0, 1'b1, "restart");
        wait_done(1, 0, "restart");

        // SETTLE=0, identical netlists, start pulsed mid-sweep
        fa_mask = 3'b000; fb_mask = 3'b000;
        start_sweep(0, 1'b0, 1'b1, "s0");
        wait_done(0, 20, "s0");

        // Reset in mid-sweep at vec=40
        start_sweep(1, 1'b0, 1'b0, "rstmid");
        wait_vec1(6'd40, "rstmid");
        rst_n = 1'b0;
        #1;
        check_zero1("rstmid_async");
        @(negedge clk);
        rst_n = 1'b1;
        fa_vec = 6'd63; fa_mask = 3'b111;
        start_sweep(1, 1'b0, 1'b1, "after_rst");
        wait_done(1, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
